// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared router widths, depths and header field positions
package router_pkg;

  localparam int ROUTER_DATA_W     = 8;
  localparam int ROUTER_FIFO_DEPTH = 16;

  // Header byte layout: [7:2] payload length, [1:0] destination
  localparam int ROUTER_LEN_MSB  = 7;
  localparam int ROUTER_LEN_LSB  = 2;
  localparam int ROUTER_ADDR_MSB = 1;
  localparam int ROUTER_ADDR_LSB = 0;

  localparam int ROUTER_PKT_CNT_W = ROUTER_LEN_MSB - ROUTER_LEN_LSB + 2;

  typedef logic [ROUTER_PKT_CNT_W-1:0] pkt_cnt_t;

endpackage

// File: rtl/router_fifo.sv
// rtl/router_fifo.sv - per-destination output FIFO with read-side packet framing
module router_fifo
  import router_pkg::*;
#(
  parameter int DATA_W = ROUTER_DATA_W,
  parameter int DEPTH  = ROUTER_FIFO_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              soft_reset,
  input  logic              we,
  input  logic              lfd_state,
  input  logic [DATA_W-1:0] din,
  input  logic              re,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              dout_hdr,
  output logic              pkt_end,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   occupancy
);

  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [DATA_W:0] mem [DEPTH];
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  pkt_cnt_t        pkt_cnt;
  logic [DATA_W:0] rd_entry;
  logic            wr_ok;
  logic            rd_ok;
  logic            flush;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                     (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign occupancy = wr_ptr - rd_ptr;

  assign flush    = !rstn || soft_reset;
  assign wr_ok    = we && !full;
  assign rd_ok    = re && !empty;
  assign rd_entry = mem[rd_ptr[ADDR_W-1:0]];

  // Storage is never cleared; flushing the pointers makes old entries unreachable
  always_ff @(posedge clk) begin
    if (!flush && wr_ok) begin
      mem[wr_ptr[ADDR_W-1:0]] <= {lfd_state, din};
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pkt_cnt    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_hdr   <= 1'b0;
      pkt_end    <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_ok) begin
        rd_ptr     <= rd_ptr + PTR_ONE;
        dout       <= rd_entry[DATA_W-1:0];
        dout_hdr   <= rd_entry[DATA_W];
        dout_valid <= 1'b1;
        // A header always reloads, even mid-packet; count covers payload plus parity
        if (rd_entry[DATA_W]) begin
          pkt_cnt <= {1'b0, rd_entry[ROUTER_LEN_MSB:ROUTER_LEN_LSB]} + pkt_cnt_t'(1);
          pkt_end <= 1'b0;
        end else if (pkt_cnt != '0) begin
          pkt_cnt <= pkt_cnt - pkt_cnt_t'(1);
          pkt_end <= (pkt_cnt == pkt_cnt_t'(1));
        end else begin
          pkt_end <= 1'b0;
        end
      end else begin
        dout_valid <= 1'b0;
        pkt_end    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_router_fifo.sv
// tb/tb_router_fifo.sv - randomized and directed bench for router_fifo against a queue model
module tb_router_fifo;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       soft_reset = 1'b0;
  logic       we = 1'b0;
  logic       lfd_state = 1'b0;
  logic [7:0] din = 8'h00;
  logic       re = 1'b0;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_hdr;
  logic       pkt_end;
  logic       full;
  logic       empty;
  logic [4:0] occupancy;

  router_fifo dut (
    .clk       (clk),
    .rstn      (rstn),
    .soft_reset(soft_reset),
    .we        (we),
    .lfd_state (lfd_state),
    .din       (din),
    .re        (re),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_hdr  (dout_hdr),
    .pkt_end   (pkt_end),
    .full      (full),
    .empty     (empty),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: queue of {header flag, byte} plus remaining-bytes-in-packet count
  logic [8:0] q[$];
  int         remaining = 0;
  logic [7:0] exp_dout = 8'h00;
  logic       exp_valid = 1'b0;
  logic       exp_hdr = 1'b0;
  logic       exp_end = 1'b0;
  logic       seen_aa;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    check("valid", dout_valid, exp_valid);
    check("dout", dout, exp_dout);
    if (exp_valid) check("hdr", dout_hdr, exp_hdr);
    check("pkt_end", pkt_end, exp_end);
    check("occupancy", occupancy, q.size());
    check("empty", empty, q.size() == 0);
    check("full", full, q.size() == 16);
    check("occ_bound", occupancy <= 5'd16, 1);
  endtask

  task automatic model_clear();
    q.delete();
    remaining = 0;
    exp_dout  = 8'h00;
    exp_valid = 1'b0;
    exp_hdr   = 1'b0;
    exp_end   = 1'b0;
  endtask

  // One clock: inputs applied now, model advanced on pre-edge occupancy, outputs checked after the edge
  task automatic step(input logic w, input logic l, input logic [7:0] d, input logic r);
    logic       can_rd;
    logic       can_wr;
    logic [8:0] e;
    we = w; lfd_state = l; din = d; re = r;
    can_rd = r && (q.size() != 0);
    can_wr = w && (q.size() != 16);
    @(posedge clk); #1;
    we = 1'b0; re = 1'b0; lfd_state = 1'b0;
    exp_end = 1'b0;
    if (can_rd) begin
      e = q.pop_front();
      exp_dout  = e[7:0];
      exp_hdr   = e[8];
      exp_valid = 1'b1;
      if (e[8]) remaining = int'(e[7:2]) + 1;
      else if (remaining > 0) begin
        exp_end = (remaining == 1);
        remaining--;
      end
    end else begin
      exp_valid = 1'b0;
    end
    if (can_wr) q.push_back({l, d});
    check_outputs();
  endtask

  task automatic wr(input logic l, input logic [7:0] d);
    step(1'b1, l, d, 1'b0);
  endtask

  task automatic rd();
    step(1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic drain();
    int n;
    n = q.size();
    for (int i = 0; i < n; i++) rd();
  endtask

  task automatic flush(input logic w, input logic r);
    soft_reset = 1'b1; we = w; re = r; din = 8'hC3; lfd_state = 1'b0;
    @(posedge clk); #1;
    soft_reset = 1'b0; we = 1'b0; re = 1'b0;
    model_clear();
    check_outputs();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_occ", occupancy, 0);
    check("rst_dout", dout, 0);
    check("rst_valid", dout_valid, 0);
    check("rst_hdr", dout_hdr, 0);
    check("rst_end", pkt_end, 0);
    rstn = 1'b1;

    // Basic packet: length 3, dest 1
    wr(1'b1, 8'h0D); wr(1'b0, 8'h11); wr(1'b0, 8'h22); wr(1'b0, 8'h33); wr(1'b0, 8'h3E);
    rd(); check("p1_hdr", dout_hdr, 1);
    rd(); rd(); rd();
    rd(); check("p1_parity", dout, 8'h3E); check("p1_end", pkt_end, 1);
    check("p1_empty", empty, 1);

    // Fill, overflow write dropped, drain in order
    for (int i = 0; i < 16; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      if (b == 8'hAA) b = 8'h55;
      wr(1'b0, b);
    end
    check("fill_full", full, 1);
    check("fill_occ", occupancy, 16);
    wr(1'b0, 8'hAA);
    seen_aa = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rd();
      if (dout == 8'hAA) seen_aa = 1'b1;
    end
    check("no_aa", seen_aa, 0);

    // Simultaneous read/write at full and at empty
    for (int i = 0; i < 16; i++) wr(1'b0, 8'(i + 1));
    step(1'b1, 1'b0, 8'hAA, 1'b1);
    check("full_rw_occ", occupancy, 15);
    seen_aa = 1'b0;
    for (int i = 0; i < 15; i++) begin
      rd();
      if (dout == 8'hAA) seen_aa = 1'b1;
    end
    check("full_rw_absent", seen_aa, 0);
    step(1'b1, 1'b0, 8'h77, 1'b1);
    check("empty_rw_occ", occupancy, 1);
    check("empty_rw_valid", dout_valid, 0);
    drain();

    // Zero-length payload
    wr(1'b1, 8'h02); wr(1'b0, 8'h02);
    rd(); rd();
    check("zlen_end", pkt_end, 1);
    check("zlen_dout", dout, 8'h02);

    // Flush mid-packet (length 10), then a clean packet
    wr(1'b1, 8'h29);
    for (int i = 0; i < 11; i++) wr(1'b0, 8'(8'h40 + i));
    rd(); rd(); rd();
    flush(1'b1, 1'b1);
    check("flush_empty", empty, 1);
    check("flush_dout", dout, 0);
    check("flush_valid", dout_valid, 0);
    wr(1'b1, 8'h09); wr(1'b0, 8'h55); wr(1'b0, 8'h66); wr(1'b0, 8'h39);
    rd(); rd(); rd();
    check("post_flush_no_end", pkt_end, 0);
    rd();
    check("post_flush_end", pkt_end, 1);
    check("post_flush_dout", dout, 8'h39);

    // Random traffic: short packets and orphan bytes, pointers wrap many times
    for (int i = 0; i < 400; i++) begin
      logic w;
      logic r;
      logic l;
      logic [7:0] d;
      w = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 5) == 0);
      d = 8'($urandom);
      if (l) d[7:2] = 6'($urandom_range(0, 4));
      step(w, l, d, r);
      if ($urandom_range(0, 150) == 0) flush(1'b1, 1'b1);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
